// File: rtl/mpfifo_pkg.sv
// Shared pointer arithmetic and protocol-assertion macros for the multi-port FIFO
// and the issue queue.
`ifndef MPFIFO_PROTO_ASSERT
`define MPFIFO_PROTO_ASSERT(lbl, clk, rst_n, cond, msg) \
  lbl: assert property (@(posedge clk) disable iff (!(rst_n)) (cond)) \
    else $warning(msg);
`endif

package mpfifo_pkg;

  // Pointers are aw index bits plus one wrap bit; DEPTH is a power of two, so
  // plain modular arithmetic on aw+1 bits carries the wrap bit correctly.
  function automatic logic [31:0] ptr_mask(input int unsigned aw);
    return (32'd1 << (aw + 1)) - 32'd1;
  endfunction

  function automatic logic [31:0] ptr_add(input logic [31:0] ptr,
                                          input logic [31:0] n,
                                          input int unsigned aw);
    return (ptr + n) & ptr_mask(aw);
  endfunction

  function automatic logic [31:0] ptr_count(input logic [31:0] head,
                                            input logic [31:0] tail,
                                            input int unsigned aw);
    return (tail - head) & ptr_mask(aw);
  endfunction

endpackage

// File: rtl/multi_port_fifo_ptr.sv
// fifo_ptr: wrap-bit pointer register with clear, load and advance-by-n.
module fifo_ptr
  import mpfifo_pkg::*;
#(
  parameter int AW     = 4,
  parameter int NW_ADV = 5
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              i_clr,
  input  logic              i_load,
  input  logic [AW:0]       i_load_val,
  input  logic [NW_ADV-1:0] i_adv,
  output logic [AW:0]       o_ptr
);

  localparam int PW = AW + 1;

  logic [PW-1:0] r_ptr;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)      r_ptr <= '0;
    else if (i_clr)  r_ptr <= '0;
    else if (i_load) r_ptr <= i_load_val;
    else             r_ptr <= PW'(ptr_add(32'(r_ptr), 32'(i_adv), AW));
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/multi_port_fifo.sv
// multi_port_fifo: NQ_PORTS-in / DQ_PORTS-out FIFO with occupancy flags and
// branch-recover truncation. Define MPFIFO_BYPASS_EN for same-cycle bypass.
module multi_port_fifo
  import mpfifo_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int DEPTH        = 16,
  parameter int NQ_PORTS     = 2,
  parameter int DQ_PORTS     = 2,
  parameter int RECOVER_KEEP = 1,
  parameter int AF_THRESH    = DEPTH - NQ_PORTS,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int NW = $clog2(NQ_PORTS + 1),
  localparam int DW = $clog2(DQ_PORTS + 1)
) (
  input  logic                           CLK,
  input  logic                           RESET,
  input  logic                           FLUSH_IN,
  input  logic                           RECOVER,
  input  logic [NW-1:0]                  NQ_COUNT,
  input  logic [NQ_PORTS*DATA_WIDTH-1:0] Q_IN,
  output logic                           NQ_ACK,
  input  logic [DW-1:0]                  DQ_COUNT,
  output logic [DQ_PORTS*DATA_WIDTH-1:0] Q_OUT,
  output logic [DQ_PORTS-1:0]            VALID_OUT,
  output logic [CW-1:0]                  COUNT_OUT,
  output logic [CW-1:0]                  FREE_OUT,
  output logic                           FULL_OUT,
  output logic                           EMPTY_OUT,
  output logic                           ALMOST_FULL_OUT
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [1:0]            r_rst_sync;
  logic                  w_rst_n;
  logic [PW-1:0]         w_head, w_tail, w_head_next, w_tail_load;
  logic [CW-1:0]         w_count, w_free, w_enq, w_avail, w_vcnt, w_deq;
  logic [CW-1:0]         w_left, w_keep;
  logic                  w_ack;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Assert immediately, release two clocks after RESET rises.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_count = CW'(ptr_count(32'(w_head), 32'(w_tail), AW));
  assign w_free  = CW'(DEPTH) - w_count;

  // Room is judged on the pre-cycle free space; same-cycle dequeues do not help.
  assign w_ack = w_rst_n && !FLUSH_IN && !RECOVER && (CW'(NQ_COUNT) <= w_free);
  assign w_enq = w_ack ? CW'(NQ_COUNT) : '0;

`ifdef MPFIFO_BYPASS_EN
  assign w_avail = w_count + w_enq;
`else
  assign w_avail = w_count;
`endif

  assign w_vcnt = (w_avail > CW'(DQ_PORTS)) ? CW'(DQ_PORTS) : w_avail;
  assign w_deq  = (CW'(DQ_COUNT) > w_vcnt) ? w_vcnt : CW'(DQ_COUNT);

  // RECOVER keeps the oldest survivors after this cycle's dequeue, relative to head.
  assign w_left      = w_count - w_deq;
  assign w_keep      = (w_left > CW'(RECOVER_KEEP)) ? CW'(RECOVER_KEEP) : w_left;
  assign w_head_next = PW'(ptr_add(32'(w_head), 32'(w_deq), AW));
  assign w_tail_load = PW'(ptr_add(32'(w_head_next), 32'(w_keep), AW));

  fifo_ptr #(.AW(AW), .NW_ADV(CW)) u_head (
    .CLK        (CLK),
    .RESET      (w_rst_n),
    .i_clr      (FLUSH_IN),
    .i_load     (1'b0),
    .i_load_val ('0),
    .i_adv      (w_deq),
    .o_ptr      (w_head)
  );

  fifo_ptr #(.AW(AW), .NW_ADV(CW)) u_tail (
    .CLK        (CLK),
    .RESET      (w_rst_n),
    .i_clr      (FLUSH_IN),
    .i_load     (RECOVER),
    .i_load_val (w_tail_load),
    .i_adv      (w_enq),
    .o_ptr      (w_tail)
  );

  // Storage is data-only and never reset; outputs are masked by VALID_OUT.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < NQ_PORTS; i++) begin
      if (CW'(i) < w_enq)
        r_mem[AW'(w_tail[AW-1:0] + AW'(i))] <= Q_IN[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_comb begin
    Q_OUT     = '0;
    VALID_OUT = '0;
    for (int i = 0; i < DQ_PORTS; i++) begin
      if (CW'(i) < w_count) begin
        VALID_OUT[i]                      = 1'b1;
        Q_OUT[i*DATA_WIDTH +: DATA_WIDTH] = r_mem[AW'(w_head[AW-1:0] + AW'(i))];
      end
`ifdef MPFIFO_BYPASS_EN
      else if (CW'(i) < w_avail) begin
        VALID_OUT[i]                      = 1'b1;
        Q_OUT[i*DATA_WIDTH +: DATA_WIDTH] =
          Q_IN[(i - int'(w_count))*DATA_WIDTH +: DATA_WIDTH];
      end
`endif
    end
  end

  assign NQ_ACK          = w_ack;
  assign COUNT_OUT       = w_count;
  assign FREE_OUT        = w_free;
  assign EMPTY_OUT       = (w_head == w_tail);
  assign FULL_OUT        = (w_head[AW-1:0] == w_tail[AW-1:0]) && (w_head[AW] != w_tail[AW]);
  assign ALMOST_FULL_OUT = (int'(w_count) >= AF_THRESH);

  `MPFIFO_PROTO_ASSERT(a_dq_overrun, CLK, w_rst_n, (CW'(DQ_COUNT) <= w_vcnt),
                       "multi_port_fifo: DQ_COUNT exceeds valid lanes, clamped")

endmodule

// File: tb/tb_multi_port_fifo.sv
// Directed testbench for multi_port_fifo (DEPTH=8, 2 lanes each way, keep 1, AF at 6).
module tb_multi_port_fifo;

  logic        CLK, RESET, FLUSH_IN, RECOVER, NQ_ACK;
  logic [1:0]  NQ_COUNT, DQ_COUNT, VALID_OUT;
  logic [63:0] Q_IN, Q_OUT;
  logic [3:0]  COUNT_OUT, FREE_OUT;
  logic        FULL_OUT, EMPTY_OUT, ALMOST_FULL_OUT;

  int tests_run = 0;
  int tests_failed = 0;

  multi_port_fifo #(
    .DATA_WIDTH(32), .DEPTH(8), .NQ_PORTS(2), .DQ_PORTS(2),
    .RECOVER_KEEP(1), .AF_THRESH(6)
  ) dut (
    .CLK(CLK), .RESET(RESET), .FLUSH_IN(FLUSH_IN), .RECOVER(RECOVER),
    .NQ_COUNT(NQ_COUNT), .Q_IN(Q_IN), .NQ_ACK(NQ_ACK), .DQ_COUNT(DQ_COUNT),
    .Q_OUT(Q_OUT), .VALID_OUT(VALID_OUT), .COUNT_OUT(COUNT_OUT), .FREE_OUT(FREE_OUT),
    .FULL_OUT(FULL_OUT), .EMPTY_OUT(EMPTY_OUT), .ALMOST_FULL_OUT(ALMOST_FULL_OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_in(input int nq, input logic [31:0] a, input logic [31:0] b,
                        input int dq, input logic rec, input logic fl);
    NQ_COUNT = 2'(nq);
    Q_IN     = {b, a};
    DQ_COUNT = 2'(dq);
    RECOVER  = rec;
    FLUSH_IN = fl;
  endtask

  task automatic idle();
    set_in(0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_flush();
    set_in(0, 32'h0, 32'h0, 0, 1'b0, 1'b1);
    tick();
    idle();
  endtask

  task automatic test_reset();
    #10;
    tests_run++; if (COUNT_OUT !== 4'd0) begin tests_failed++; $display("FAIL rst_count: got %0d expected 0", COUNT_OUT); end
    tests_run++; if (FREE_OUT !== 4'd8) begin tests_failed++; $display("FAIL rst_free: got %0d expected 8", FREE_OUT); end
    tests_run++; if ({EMPTY_OUT, FULL_OUT, ALMOST_FULL_OUT} !== 3'b100) begin tests_failed++; $display("FAIL rst_flags: got %b expected 100", {EMPTY_OUT, FULL_OUT, ALMOST_FULL_OUT}); end
    tests_run++; if (VALID_OUT !== 2'b00 || Q_OUT !== 64'h0) begin tests_failed++; $display("FAIL rst_out: got valid %b q %h expected 00 / 0", VALID_OUT, Q_OUT); end
    set_in(2, 32'hA, 32'hB, 0, 1'b0, 1'b0);
    #1;
    tests_run++; if (NQ_ACK !== 1'b0) begin tests_failed++; $display("FAIL rst_ack: got %b expected 0", NQ_ACK); end
    idle();
    @(negedge CLK);
    RESET = 1'b1;
    repeat (3) tick();
    set_in(2, 32'hA, 32'hB, 0, 1'b0, 1'b0);
    #1;
    tests_run++; if (NQ_ACK !== 1'b1) begin tests_failed++; $display("FAIL first_ack: got %b expected 1", NQ_ACK); end
    tick();
    idle();
    #1;
    tests_run++; if (Q_OUT !== {32'hB, 32'hA}) begin tests_failed++; $display("FAIL first_q: got %h expected %h", Q_OUT, {32'hB, 32'hA}); end
    tests_run++; if (VALID_OUT !== 2'b11 || COUNT_OUT !== 4'd2) begin tests_failed++; $display("FAIL first_vc: got valid %b count %0d expected 11 / 2", VALID_OUT, COUNT_OUT); end
  endtask

  task automatic test_fill();
    do_flush();
    for (int g = 0; g < 4; g++) begin
      set_in(2, 32'h100 + 32'(2*g), 32'h101 + 32'(2*g), 0, 1'b0, 1'b0);
      #1;
      tests_run++; if (NQ_ACK !== 1'b1) begin tests_failed++; $display("FAIL fill_ack%0d: got %b expected 1", g, NQ_ACK); end
      tick();
    end
    idle();
    #1;
    tests_run++; if (FULL_OUT !== 1'b1 || FREE_OUT !== 4'd0 || COUNT_OUT !== 4'd8) begin tests_failed++; $display("FAIL full_state: got full %b free %0d count %0d expected 1 / 0 / 8", FULL_OUT, FREE_OUT, COUNT_OUT); end
    tests_run++; if (ALMOST_FULL_OUT !== 1'b1 || EMPTY_OUT !== 1'b0) begin tests_failed++; $display("FAIL full_af: got af %b empty %b expected 1 / 0", ALMOST_FULL_OUT, EMPTY_OUT); end
    set_in(2, 32'hDEAD, 32'hBEEF, 0, 1'b0, 1'b0);
    #1;
    tests_run++; if (NQ_ACK !== 1'b0) begin tests_failed++; $display("FAIL full_nack: got %b expected 0", NQ_ACK); end
    tick();
    set_in(0, 32'h0, 32'h0, 0, 1'b0, 1'b0);
    #1;
    tests_run++; if (NQ_ACK !== 1'b1) begin tests_failed++; $display("FAIL zero_ack: got %b expected 1", NQ_ACK); end
    set_in(2, 32'hDEAD, 32'hBEEF, 2, 1'b0, 1'b0);
    #1;
    tests_run++; if (NQ_ACK !== 1'b0) begin tests_failed++; $display("FAIL full_rw_nack: got %b expected 0", NQ_ACK); end
    tick();
    idle();
    #1;
    tests_run++; if (COUNT_OUT !== 4'd6 || FULL_OUT !== 1'b0 || ALMOST_FULL_OUT !== 1'b1) begin tests_failed++; $display("FAIL full_rw_cnt: got count %0d full %b af %b expected 6 / 0 / 1", COUNT_OUT, FULL_OUT, ALMOST_FULL_OUT); end
    tests_run++; if (Q_OUT !== {32'h103, 32'h102}) begin tests_failed++; $display("FAIL full_rw_q: got %h expected %h", Q_OUT, {32'h103, 32'h102}); end
  endtask

  task automatic test_wrap();
    do_flush();
    // Offset pointers by one slot so 2-entry groups straddle slot 7 -> 0.
    set_in(1, 32'hEE, 32'h0, 0, 1'b0, 1'b0);
    tick();
    set_in(0, 32'h0, 32'h0, 1, 1'b0, 1'b0);
    tick();
    set_in(2, 32'd0, 32'd1, 0, 1'b0, 1'b0);
    tick();
    for (int c = 0; c < 20; c++) begin
      if (c < 19) set_in(2, 32'(2*c + 2), 32'(2*c + 3), 2, 1'b0, 1'b0);
      else        set_in(0, 32'h0, 32'h0, 2, 1'b0, 1'b0);
      #1;
      tests_run++; if (Q_OUT !== {32'(2*c + 1), 32'(2*c)} || VALID_OUT !== 2'b11) begin tests_failed++; $display("FAIL wrap_q%0d: got %h valid %b expected %h / 11", c, Q_OUT, VALID_OUT, {32'(2*c + 1), 32'(2*c)}); end
      tests_run++; if (COUNT_OUT !== 4'd2) begin tests_failed++; $display("FAIL wrap_cnt%0d: got %0d expected 2", c, COUNT_OUT); end
      tick();
    end
    idle();
    #1;
    tests_run++; if (COUNT_OUT !== 4'd0 || EMPTY_OUT !== 1'b1) begin tests_failed++; $display("FAIL wrap_end: got count %0d empty %b expected 0 / 1", COUNT_OUT, EMPTY_OUT); end
  endtask

  task automatic test_recover();
    do_flush();
    set_in(2, 32'd10, 32'd11, 0, 1'b0, 1'b0); tick();
    set_in(2, 32'd12, 32'd13, 0, 1'b0, 1'b0); tick();
    set_in(1, 32'd14, 32'd0, 0, 1'b0, 1'b0);  tick();
    idle();
    #1;
    tests_run++; if (COUNT_OUT !== 4'd5) begin tests_failed++; $display("FAIL rec_pre: got %0d expected 5", COUNT_OUT); end
    set_in(2, 32'hF0, 32'hF1, 1, 1'b1, 1'b0);
    #1;
    tests_run++; if (NQ_ACK !== 1'b0) begin tests_failed++; $display("FAIL rec_nack: got %b expected 0", NQ_ACK); end
    tick();
    idle();
    #1;
    tests_run++; if (COUNT_OUT !== 4'd1 || VALID_OUT !== 2'b01) begin tests_failed++; $display("FAIL rec_cnt: got count %0d valid %b expected 1 / 01", COUNT_OUT, VALID_OUT); end
    tests_run++; if (Q_OUT !== {32'h0, 32'd11}) begin tests_failed++; $display("FAIL rec_q: got %h expected %h", Q_OUT, {32'h0, 32'd11}); end
    set_in(0, 32'h0, 32'h0, 1, 1'b1, 1'b0);
    tick();
    idle();
    #1;
    tests_run++; if (COUNT_OUT !== 4'd0 || EMPTY_OUT !== 1'b1 || Q_OUT !== 64'h0) begin tests_failed++; $display("FAIL rec_empty: got count %0d empty %b q %h expected 0 / 1 / 0", COUNT_OUT, EMPTY_OUT, Q_OUT); end
  endtask

  task automatic test_clamp_flush();
    do_flush();
    set_in(1, 32'h55, 32'h0, 0, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    tests_run++; if (COUNT_OUT !== 4'd1) begin tests_failed++; $display("FAIL clamp_pre: got %0d expected 1", COUNT_OUT); end
    set_in(0, 32'h0, 32'h0, 2, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    tests_run++; if (COUNT_OUT !== 4'd0 || EMPTY_OUT !== 1'b1) begin tests_failed++; $display("FAIL clamp_cnt: got count %0d empty %b expected 0 / 1", COUNT_OUT, EMPTY_OUT); end
    set_in(2, 32'h66, 32'h77, 0, 1'b0, 1'b0);
    tick();
    set_in(2, 32'h88, 32'h99, 0, 1'b0, 1'b1);
    #1;
    tests_run++; if (NQ_ACK !== 1'b0) begin tests_failed++; $display("FAIL flush_nack: got %b expected 0", NQ_ACK); end
    tick();
    idle();
    #1;
    tests_run++; if (COUNT_OUT !== 4'd0 || EMPTY_OUT !== 1'b1 || FREE_OUT !== 4'd8 || VALID_OUT !== 2'b00) begin tests_failed++; $display("FAIL flush_state: got count %0d empty %b free %0d valid %b expected 0 / 1 / 8 / 00", COUNT_OUT, EMPTY_OUT, FREE_OUT, VALID_OUT); end
  endtask

  task automatic test_async_reset();
    set_in(2, 32'h123, 32'h456, 0, 1'b0, 1'b0);
    tick();
    idle();
    #2;
    RESET = 1'b0;
    #1;
    tests_run++; if (COUNT_OUT !== 4'd0 || FREE_OUT !== 4'd8 || EMPTY_OUT !== 1'b1) begin tests_failed++; $display("FAIL arst_cnt: got count %0d free %0d empty %b expected 0 / 8 / 1", COUNT_OUT, FREE_OUT, EMPTY_OUT); end
    tests_run++; if (VALID_OUT !== 2'b00 || Q_OUT !== 64'h0) begin tests_failed++; $display("FAIL arst_out: got valid %b q %h expected 00 / 0", VALID_OUT, Q_OUT); end
    @(negedge CLK);
    RESET = 1'b1;
    repeat (3) tick();
    #1;
    tests_run++; if (NQ_ACK !== 1'b1 || COUNT_OUT !== 4'd0) begin tests_failed++; $display("FAIL arst_rel: got ack %b count %0d expected 1 / 0", NQ_ACK, COUNT_OUT); end
  endtask

  task automatic test_bypass();
    idle();
    tick();
    set_in(1, 32'hC0DE, 32'h0, 0, 1'b0, 1'b0);
    #1;
`ifdef MPFIFO_BYPASS_EN
    tests_run++; if (Q_OUT[31:0] !== 32'hC0DE || VALID_OUT !== 2'b01) begin tests_failed++; $display("FAIL byp_q: got %h valid %b expected c0de / 01", Q_OUT[31:0], VALID_OUT); end
    set_in(1, 32'hC0DE, 32'h0, 1, 1'b0, 1'b0);
    tick();
    idle();
    #1;
    tests_run++; if (COUNT_OUT !== 4'd0) begin tests_failed++; $display("FAIL byp_cnt: got %0d expected 0", COUNT_OUT); end
`else
    tests_run++; if (VALID_OUT !== 2'b00 || Q_OUT !== 64'h0) begin tests_failed++; $display("FAIL nobyp_q: got valid %b q %h expected 00 / 0", VALID_OUT, Q_OUT); end
    tick();
    idle();
    #1;
    tests_run++; if (Q_OUT[31:0] !== 32'hC0DE || COUNT_OUT !== 4'd1) begin tests_failed++; $display("FAIL nobyp_lat: got %h count %0d expected c0de / 1", Q_OUT[31:0], COUNT_OUT); end
`endif
  endtask

  initial begin
    idle();
    RESET = 1'b1;
    #1;
    RESET = 1'b0;
    test_reset();
    test_fill();
    test_wrap();
    test_recover();
    test_clamp_flush();
    test_async_reset();
    test_bypass();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/multi_port_fifo.md
# multi_port_fifo

Parametrised multi-port FIFO that succeeds the single-port queue in the OoO front end: accepts up to NQ_PORTS entries and delivers up to DQ_PORTS entries per cycle. It also reports occupancy and free space, and on branch RECOVER retains a configurable number of the oldest entries. Unlike the single-port queue, all DEPTH slots are usable. It sits between fetch/decode and rename/dispatch, and serves as a generic instruction/ops buffer.

## Interface
- DATA_WIDTH, 32, bits per entry
- DEPTH, 16, slots; power of two, ≥ 4, ≥ max(NQ_PORTS, DQ_PORTS)
- NQ_PORTS, 2, enqueue lanes
- DQ_PORTS, 2, dequeue lanes
- RECOVER_KEEP, 1, oldest entries kept on RECOVER (0..DEPTH)
- AF_THRESH, DEPTH-NQ_PORTS, ALMOST_FULL_OUT asserts when COUNT_OUT ≥ AF_THRESH
- Widths: CW = $clog2(DEPTH+1), NW = $clog2(NQ_PORTS+1), DW = $clog2(DQ_PORTS+1)

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-low reset
- FLUSH_IN  in  1  synchronous clear, highest priority after RESET
- RECOVER  in  1  truncate to oldest RECOVER_KEEP entries
- NQ_COUNT  in  NW  entries offered this cycle, lanes 0..NQ_COUNT-1 of Q_IN
- Q_IN  in  NQ_PORTS*DATA_WIDTH  lane i at bits [i*DATA_WIDTH +: DATA_WIDTH]; lane 0 oldest
- NQ_ACK  out  1  offered group accepted (all-or-nothing)
- DQ_COUNT  in  DW  entries consumed this cycle from Q_OUT lanes 0..DQ_COUNT-1
- Q_OUT  out  DQ_PORTS*DATA_WIDTH  lane i = i-th oldest entry; zero when VALID_OUT[i]=0
- VALID_OUT  out  DQ_PORTS  lane i holds a valid entry
- COUNT_OUT  out  CW  occupancy
- FREE_OUT  out  CW  DEPTH − COUNT_OUT
- FULL_OUT / EMPTY_OUT / ALMOST_FULL_OUT  out  1 each  status flags

## Operation
- Head/tail pointers are $clog2(DEPTH)+1 bits, with the MSB as the wrap bit.
  - Empty: pointers equal.
  - Full: indices equal, wrap bits differ.
- Enqueue:
  - NQ_ACK = (NQ_COUNT ≤ FREE_OUT) && !RECOVER && !FLUSH_IN. FREE_OUT is the pre-cycle value; same-cycle dequeues do not create room.
  - On ACK, lanes 0..NQ_COUNT-1 are written to tail, tail+1, … with modulo-DEPTH wrap.
  - NQ_COUNT=0 gives NQ_ACK=1 with no effect.
- Dequeue:
  - Accepted count = min(DQ_COUNT, number of valid lanes); head advances by that amount.
  - DQ_COUNT greater than the valid lanes is a protocol error. It is clamped, not fatal, and flagged by a simulation assertion.
- Simultaneous enqueue and dequeue are both applied: COUNT_next = COUNT + enq − deq.
- RECOVER:
  - Dequeue is applied first.
  - Then tail = head_next + min(RECOVER_KEEP, COUNT − deq), relative to head. Tail is never set to an absolute index.
  - Enqueue is suppressed.
- FLUSH_IN zeroes both pointers; storage is not cleared.
- The storage array is not reset. Output zero-masking keeps Q_OUT deterministic.

## Timing
- Reset (async assert, sync-safe deassert) and FLUSH_IN produce:
  - head = tail = 0; COUNT_OUT = 0; FREE_OUT = DEPTH.
  - EMPTY_OUT = 1; FULL_OUT = 0; ALMOST_FULL_OUT = (AF_THRESH == 0).
  - VALID_OUT = 0; Q_OUT = 0.
  - NQ_ACK = 0 only when FLUSH_IN is asserted or RESET is low.
- Write latency is 1 cycle. An entry accepted at edge N is visible on Q_OUT after edge N (from cycle N+1).
- Q_OUT, VALID_OUT and all flags are combinational from registered pointers and storage, with no input-to-output paths. The exception is MPFIFO_BYPASS_EN.
- NQ_ACK is combinational from NQ_COUNT, RECOVER, FLUSH_IN and registered state.
- Wrap-around is seamless across any lane boundary. A group may straddle slot DEPTH-1 → 0.
- Reset mid-operation discards all state immediately. There is no partial write.

## Configuration
- MPFIFO_BYPASS_EN defined:
  - When COUNT_OUT < DQ_PORTS, accepted enqueue lanes fill Q_OUT lanes COUNT_OUT.. in the same cycle, with VALID_OUT set.
  - The dequeue limit becomes COUNT + enq. A bypassed entry consumed in the same cycle never occupies a slot.
  - This adds a combinational path Q_IN/NQ_COUNT → Q_OUT/VALID_OUT.
- MPFIFO_BYPASS_EN undefined: behaviour is as described above, with a strict 1-cycle latency.

## Structure
- Package mpfifo_pkg holds:
  - Pointer-advance function ptr_add(ptr, n), with wrap-bit handling.
  - Occupancy function ptr_count(head, tail).
  - Protocol-assertion macros shared with the issue queue.
- One sub-module, fifo_ptr, is natural. It is a wrap-bit pointer register with advance-by-n, load and clear. It is instantiated twice (head and tail).
- The top module contains storage, lane muxing, flag logic and bypass.

## Test plan
All scenarios use DEPTH=8, NQ_PORTS=DQ_PORTS=2, RECOVER_KEEP=1, AF_THRESH=6.
- Reset → COUNT_OUT=0, FREE_OUT=8, EMPTY_OUT=1, VALID_OUT=2'b00, Q_OUT=0. Then NQ_COUNT=2 with A,B → next cycle Q_OUT lanes = A,B, VALID_OUT=2'b11, COUNT_OUT=2.
- Fill with four 2-entry groups → FULL_OUT=1 and FREE_OUT=0 after the 4th. A 5th group gets NQ_ACK=0. NQ_COUNT=2 with DQ_COUNT=2 while full → NQ_ACK=0, COUNT_OUT=6.
- Wrap: continuous 2-in/2-out for 20 cycles with sequential data 0..39 → outputs in strict order, COUNT_OUT constant at 2, group straddling slot 7→0 correct.
- Occupancy 5 (entries 10..14), RECOVER with DQ_COUNT=1 → 10 dequeued, next COUNT_OUT=1, Q_OUT lane0=11. RECOVER at occupancy 1 with DQ_COUNT=1 → empty.
- DQ_COUNT=2 with COUNT_OUT=1 → assertion fires, COUNT_OUT=0. FLUSH_IN with simultaneous NQ → NQ_ACK=0, empty next cycle.
- RESET asserted mid-stream between edges → all outputs at reset values immediately. (With MPFIFO_BYPASS_EN: empty queue, enqueue X → Q_OUT lane0=X in the same cycle; with DQ_COUNT=1, COUNT_OUT stays 0.)
